imem_loader: RTL and testbench
==============================

# imem_loader

Program-load side of the accumulator processor. It accepts a byte-stream program frame over a valid/ready interface and writes the instruction bytes into a 16-entry instruction store. It validates each frame with an XOR checksum and then flags the program as runnable. The control unit reads the same store through a combinational index port, 4-bit `Indexing` to an 8-bit instruction. The loader is therefore the writer for the store the control unit reads.

## Interface
- `INSTR_W`, 8, instruction/byte width
- `DEPTH`, 16, instruction store entries
- `ADDR_W`, 4, store index width (log2 DEPTH)

- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  stream byte valid
- `in_data`  in  8  stream byte
- `in_ready`  out  1  loader can accept; transfer = in_valid & in_ready at rising edge
- `abort`  in  1  synchronous frame abort
- `rd_index`  in  4  control-unit read index (`Indexing`)
- `rd_instr`  out  8  store[rd_index], combinational
- `prog_valid`  out  1  store holds a checksum-verified program
- `prog_len`  out  5  instruction count of last verified program (1..16)
- `busy`  out  1  frame in progress (state ≠ S_HDR)
- `done`  out  1  one-cycle pulse: frame verified
- `err`  out  1  one-cycle pulse: bad header or bad checksum

## Operation
- Frame format: header byte N (1..16), then N instruction bytes, then one checksum byte equal to the XOR of the N instruction bytes.
- FSM states: S_HDR, S_DATA, S_SUM, S_RESP.
- **S_HDR.** On transfer:
  - If N=0 or N>16: pulse `err` in S_RESP and return to S_HDR.
  - Otherwise: latch count=N, idx=0, csum=0, clear `prog_valid`, and go to S_DATA.
- **S_DATA.** On each transfer:
  - store[idx] ← in_data; csum ^= in_data; idx++.
  - After the byte with idx=count-1, go to S_SUM.
- **S_SUM.** On transfer, compare in_data with csum and go to S_RESP.
  - Match: `done`=1, `prog_valid`←1, `prog_len`←count.
  - Mismatch: `err`=1, and `prog_valid` stays 0.
- **S_RESP.** Lasts exactly one cycle with `in_ready`=0, then returns to S_HDR.
- `in_ready` = (state ≠ S_RESP) & ~abort.
- **Abort.** `abort`=1 in any state:
  - Next state is S_HDR and no byte is accepted that cycle.
  - `prog_valid`=0 if the abort hit S_DATA or S_SUM.
  - No `done`/`err` pulse.
  - Bytes already written stay in the store.
- A bad header leaves `prog_valid` unchanged; only a header with N in 1..16 clears it.
- Idle cycles (in_valid=0) are allowed anywhere. State, idx and csum hold.

## Timing
- Reset values:
  - state=S_HDR; `in_ready`=1; `busy`, `done`, `err`, `prog_valid`=0; `prog_len`=0.
  - All store entries 0x00; idx, count, csum=0.
- A store write takes effect at the accepting edge. `rd_instr` shows the new value from the following cycle. A same-cycle read of the address being written returns the old value.
- Latency: the checksum byte is accepted at edge k. `done`/`err`/`prog_valid` are visible after edge k, and `in_ready` is low for that one cycle. The next header can be accepted at edge k+2.
- Minimum frame time is N+3 cycles.
- `done` and `err` are registered and never high together.
- Reset mid-frame returns everything to reset values immediately, including clearing the store.

## Structure
- Shared package `proc_pkg` holds:
  - `INSTR_W`, `DEPTH`, `ADDR_W`, `MAX_LEN`=16;
  - the loader state enum {S_HDR, S_DATA, S_SUM, S_RESP}.
- Sub-module `imem_regfile`:
  - 16×8 flop array with async clear on `rst`;
  - one synchronous write port (we, waddr, wdata);
  - one combinational read port, driven by `rd_index`.
- `imem_loader` holds the FSM, counters and checksum, and instantiates `imem_regfile`.

## Test plan
- Reset, then idle. Expect `in_ready`=1, `prog_valid`=0, `busy`=0, and `rd_instr`=0x00 for every rd_index 0..15.
- Send frame 03,12,34,56,70 back-to-back. Expect:
  - `done` one cycle after the 0x70 transfer, with `in_ready`=0 that cycle;
  - `prog_valid`=1, `prog_len`=3;
  - rd_index=1 → 0x34, rd_index=2 → 0x56.
- Send frame 02,AA,55,00 (correct checksum is FF). Expect `err` pulse, `done`=0, `prog_valid`=0; store[0]=AA, store[1]=55.
- Send header 00, then header 11 (N=17). Expect an `err` pulse for each with state back in S_HDR. Then send 01,5A,5A and expect `done`, `prog_len`=1.
- Send a 16-byte frame (10, bytes 00..0F, checksum 00) with random in_valid gaps. Expect `done`, `prog_len`=16, and rd_index=15 → 0x0F.
- After a good program, run two interrupted frames:
  - Assert `abort` after the 2nd data byte of the next frame. Expect no pulse, `prog_valid`=0, state S_HDR, and `in_ready`=0 while abort is high.
  - Assert `rst` mid-frame. Expect all outputs at reset values and the store cleared.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared parameters and the loader state encoding for the accumulator processor.
// The instruction store and the program loader both import this package.
package proc_pkg;
  localparam int INSTR_W = 8;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int MAX_LEN = 16;

  typedef enum logic [1:0] {
    S_HDR,
    S_DATA,
    S_SUM,
    S_RESP
  } ld_state_t;
endpackage

// File: rtl/imem_regfile.sv
// Instruction store: 16x8 flop array with one synchronous write port and one
// combinational read port. Reset clears every entry.
module imem_regfile
  import proc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  rd_index,
  output logic [INSTR_W-1:0] rd_instr
);
  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A read of the address being written returns the old value this cycle.
  assign rd_instr = mem[rd_index];
endmodule

// File: rtl/imem_loader.sv
// Program loader: receives a header/data/checksum byte frame and writes the
// instruction bytes into the store read by the control unit.
// state  | meaning
// S_HDR  | waiting for header byte N
// S_DATA | receiving N instruction bytes
// S_SUM  | waiting for the XOR checksum byte
// S_RESP | one-cycle response (done/err visible), in_ready low
module imem_loader
  import proc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_data,
  output logic               in_ready,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  rd_index,
  output logic [INSTR_W-1:0] rd_instr,
  output logic               prog_valid,
  output logic [4:0]         prog_len,
  output logic               busy,
  output logic               done,
  output logic               err
);
  ld_state_t          state_q, state_n;
  logic [4:0]         count_q, count_n;
  logic [ADDR_W-1:0]  idx_q, idx_n;
  logic [INSTR_W-1:0] csum_q, csum_n;
  logic               pv_n, done_n, err_n;
  logic [4:0]         len_n;
  logic               xfer, we;

  assign in_ready = (state_q != S_RESP) & ~abort;
  assign xfer     = in_valid & in_ready;
  assign busy     = (state_q != S_HDR);
  assign we       = xfer & (state_q == S_DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_HDR;
      count_q    <= '0;
      idx_q      <= '0;
      csum_q     <= '0;
      prog_valid <= 1'b0;
      prog_len   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_n;
      count_q    <= count_n;
      idx_q      <= idx_n;
      csum_q     <= csum_n;
      prog_valid <= pv_n;
      prog_len   <= len_n;
      done       <= done_n;
      err        <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    count_n = count_q;
    idx_n   = idx_q;
    csum_n  = csum_q;
    pv_n    = prog_valid;
    len_n   = prog_len;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (abort) begin
      // Abort drops the frame silently; partially written bytes stay in the store.
      state_n = S_HDR;
      if (state_q == S_DATA || state_q == S_SUM) pv_n = 1'b0;
    end else begin
      case (state_q)
        S_HDR: if (xfer) begin
          if (in_data == '0 || in_data > INSTR_W'(MAX_LEN)) begin
            err_n   = 1'b1;
            state_n = S_RESP;
          end else begin
            count_n = in_data[4:0];
            idx_n   = '0;
            csum_n  = '0;
            pv_n    = 1'b0;
            state_n = S_DATA;
          end
        end
        S_DATA: if (xfer) begin
          csum_n = csum_q ^ in_data;
          idx_n  = idx_q + 1'b1;
          if ({1'b0, idx_q} == count_q - 5'd1) state_n = S_SUM;
        end
        S_SUM: if (xfer) begin
          state_n = S_RESP;
          if (in_data == csum_q) begin
            done_n = 1'b1;
            pv_n   = 1'b1;
            len_n  = count_q;
          end else begin
            err_n = 1'b1;
          end
        end
        S_RESP:  state_n = S_HDR;
        default: state_n = S_HDR;
      endcase
    end
  end

  imem_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (idx_q),
    .wdata    (in_data),
    .rd_index (rd_index),
    .rd_instr (rd_instr)
  );
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected done/err responses are queued by
// the stimulus and popped by a monitor whenever the loader pulses.
module tb_imem_loader;
  import proc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       abort = 1'b0;
  logic [3:0] rd_index = '0;
  logic [7:0] rd_instr;
  logic       prog_valid;
  logic [4:0] prog_len;
  logic       busy, done, err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       d;
    logic       e;
    logic       pv;
    logic [4:0] len;
  } resp_t;
  resp_t exp_q[$];

  imem_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .abort(abort), .rd_index(rd_index),
    .rd_instr(rd_instr), .prog_valid(prog_valid), .prog_len(prog_len),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic d, input logic e, input logic pv, input logic [4:0] len);
    resp_t r;
    r.d = d; r.e = e; r.pv = pv; r.len = len;
    exp_q.push_back(r);
  endtask

  // Monitor: compare each pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (done || err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, done, err}, 32'd0);
      end else begin
        resp_t r;
        r = exp_q.pop_front();
        chk("resp_done", done, r.d);
        chk("resp_err", err, r.e);
        chk("resp_prog_valid", prog_valid, r.pv);
        chk("resp_prog_len", prog_len, r.len);
        chk("resp_in_ready_low", in_ready, 1'b0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", n < 20, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic settle_idle();
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_in_ready", in_ready, 1'b1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [7:0] exp);
    rd_index = a;
    #1 chk($sformatf("rd_instr[%0d]", a), rd_instr, exp);
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_prog_valid", prog_valid, 1'b0);
    chk("rst_prog_len", prog_len, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done_err", {done, err}, 2'b00);
    for (int i = 0; i < 16; i++) rd_chk(4'(i), 8'h00);
  endtask

  initial begin
    #23 rst = 1'b0;
    @(negedge clk);
    check_reset_state();

    // Good 3-byte frame: 12^34^56 = 70.
    send_byte(8'h03, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    push(1'b1, 1'b0, 1'b1, 5'd3);
    send_byte(8'h70, 0);
    settle_idle();
    rd_chk(4'd0, 8'h12);
    rd_chk(4'd1, 8'h34);
    rd_chk(4'd2, 8'h56);

    // Bad checksum: AA^55 = FF, send 00.
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    push(1'b0, 1'b1, 1'b0, 5'd3);
    send_byte(8'h00, 0);
    settle_idle();
    rd_chk(4'd0, 8'hAA);
    rd_chk(4'd1, 8'h55);

    // Bad headers leave prog_valid (0) and prog_len (3) unchanged.
    push(1'b0, 1'b1, 1'b0, 5'd3);
    send_byte(8'h00, 0);
    settle_idle();
    push(1'b0, 1'b1, 1'b0, 5'd3);
    send_byte(8'h11, 0);
    settle_idle();
    send_byte(8'h01, 0);
    send_byte(8'h5A, 0);
    push(1'b1, 1'b0, 1'b1, 5'd1);
    send_byte(8'h5A, 0);
    settle_idle();
    rd_chk(4'd0, 8'h5A);

    // Full-depth frame with random idle gaps: XOR of 00..0F is 00.
    send_byte(8'h10, $urandom_range(0, 2));
    for (int i = 0; i < 16; i++) send_byte(8'(i), $urandom_range(0, 2));
    push(1'b1, 1'b0, 1'b1, 5'd16);
    send_byte(8'h00, $urandom_range(0, 2));
    settle_idle();
    rd_chk(4'd15, 8'h0F);
    rd_chk(4'd7, 8'h07);

    // Abort after the 2nd data byte.
    send_byte(8'h03, 0);
    send_byte(8'hA1, 0);
    send_byte(8'hA2, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA3;
    abort    = 1'b1;
    #1 chk("abort_in_ready", in_ready, 1'b0);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_prog_valid", prog_valid, 1'b0);
    chk("abort_prog_len", prog_len, 5'd16);
    settle_idle();
    rd_chk(4'd0, 8'hA1);
    rd_chk(4'd1, 8'hA2);
    rd_chk(4'd2, 8'h02);

    // Good program, then reset mid-frame.
    send_byte(8'h01, 0);
    send_byte(8'h3C, 0);
    push(1'b1, 1'b0, 1'b1, 5'd1);
    send_byte(8'h3C, 0);
    settle_idle();
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_state();
    @(negedge clk);
    rst = 1'b0;
    settle_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
